// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit operands LSB-first.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b via inverted B and forced carry-in).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is taken on any edge where busy=0 (IDLE or DONE);
    // done pulses for one cycle with sum/cout already updated.
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             inv_b;
    logic             load_carry;
    logic             b_bit;
    logic             s_bit;
    logic             c_next;
    logic             last;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_r;
    assign inv_b      = sub_r;
    assign load_carry = sub | cin;
`else
    assign inv_b      = 1'b0;
    assign load_carry = cin;
`endif

    always_comb begin
        b_bit              = sh_b[0] ^ inv_b;
        s_bit              = sh_a[0] ^ b_bit ^ carry;
        c_next             = (sh_a[0] & b_bit) | (carry & (sh_a[0] ^ b_bit));
        res_next           = res >> 1;
        res_next[WIDTH-1]  = s_bit;
        last               = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= load_carry;
                        res   <= '0;
                        cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_r <= sub;
`endif
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry <= c_next;
                    res   <= res_next;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum   <= res_next;
                        cout  <= c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
